// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//
// Central control block for the 5-stage FETCH/DEC/EXE/MEM/WB core.  It owns
// the per-stage valid bits, drives every stage-register enable, resolves
// load-use hazards with a one-cycle stall plus bubble, squashes wrong-path
// instructions on a taken branch, selects EXE operand forwarding, and runs
// the data-memory request/acknowledge handshake with a wait timeout.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   dec_*               source registers of the instruction in DEC
//   exe_*               sources/destination and class of the EXE instruction
//   mem_*               destination and class of the MEM instruction
//   wb_*                destination of the WB instruction
//   dmem_ack            data memory completes the current access
//   pc_en, pc_sel       PC load enable and next-PC select (1 = branch target)
//   fd_en..mw_en        pipeline register enables
//   v_d, v_e, v_m, v_w  stage valid bits
//   wb_valid            register-file write qualifier
//   dmem_req            data memory request
//   fwd_a, fwd_b        EXE operand sources: 00 RF, 01 MEM, 10 WB
//   stall_cnt           saturating count of cycles with the PC held
//   mem_err             sticky memory-timeout error
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int REG_AW      = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_uses_rs1,
    input  logic              dec_uses_rs2,
    input  logic [REG_AW-1:0] exe_rs1,
    input  logic [REG_AW-1:0] exe_rs2,
    input  logic [REG_AW-1:0] exe_rd,
    input  logic              exe_is_load,
    input  logic              exe_needs_wb,
    input  logic              exe_branch_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_needs_wb,
    input  logic              mem_is_load,
    input  logic              mem_is_store,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_needs_wb,
    input  logic              dmem_ack,
    output logic              pc_en,
    output logic              pc_sel,
    output logic              fd_en,
    output logic              de_en,
    output logic              em_en,
    output logic              mw_en,
    output logic              v_d,
    output logic              v_e,
    output logic              v_m,
    output logic              v_w,
    output logic              wb_valid,
    output logic              dmem_req,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic mem_access;
    logic mem_stall;
    logic freeze;
    logic branch;
    logic rs1_hazard;
    logic rs2_hazard;
    logic load_use;
    logic mem_fwd_ok;
    logic wb_fwd_ok;

    // Hazard and handshake conditions for the current cycle.  A request that
    // is acknowledged in the same cycle does not freeze the pipeline.
    assign mem_access = v_m & (mem_is_load | mem_is_store);
    assign dmem_req   = mem_access & (state != HALT);
    assign mem_stall  = dmem_req & ~dmem_ack;
    assign freeze     = mem_stall | (state == HALT);
    assign branch     = v_e & exe_branch_taken;

    assign rs1_hazard = dec_uses_rs1 & (dec_rs1 == exe_rd);
    assign rs2_hazard = dec_uses_rs2 & (dec_rs2 == exe_rd);
    assign load_use   = v_d & v_e & exe_is_load & exe_needs_wb
                        & (rs1_hazard | rs2_hazard);

    assign wb_valid   = v_w & wb_needs_wb;

    // A load in MEM has no data yet, so it is never a forwarding source; the
    // load-use stall guarantees its consumer sees it from WB instead.
    assign mem_fwd_ok = v_m & mem_needs_wb & ~mem_is_load;
    assign wb_fwd_ok  = v_w & wb_needs_wb;

    // Stage enables in priority order: freeze, branch, load-use, normal.
    // Everything is held low while reset is asserted.
    always_comb begin
        pc_en  = 1'b0;
        pc_sel = 1'b0;
        fd_en  = 1'b0;
        de_en  = 1'b0;
        em_en  = 1'b0;
        mw_en  = 1'b0;
        if (!rst && !freeze) begin
            de_en = 1'b1;
            em_en = 1'b1;
            mw_en = 1'b1;
            if (branch) begin
                pc_en  = 1'b1;
                pc_sel = 1'b1;
                fd_en  = 1'b1;
            end else if (!load_use) begin
                pc_en = 1'b1;
                fd_en = 1'b1;
            end
        end
    end

    // Operand forwarding for EXE; the younger producer in MEM wins over WB.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (v_e) begin
            if (mem_fwd_ok && (mem_rd == exe_rs1)) begin
                fwd_a = FWD_MEM;
            end else if (wb_fwd_ok && (wb_rd == exe_rs1)) begin
                fwd_a = FWD_WB;
            end
            if (mem_fwd_ok && (mem_rd == exe_rs2)) begin
                fwd_b = FWD_MEM;
            end else if (wb_fwd_ok && (wb_rd == exe_rs2)) begin
                fwd_b = FWD_WB;
            end
        end
    end

    // Stage valid bits.  During a freeze WB is cleared so the register file
    // write is not repeated while the older stages hold.  A branch squashes
    // DEC and EXE but the branch itself moves on into MEM.  A load-use stall
    // holds DEC and sends a bubble into EXE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_d <= 1'b0;
            v_e <= 1'b0;
            v_m <= 1'b0;
            v_w <= 1'b0;
        end else if (freeze) begin
            v_w <= 1'b0;
        end else if (branch) begin
            v_d <= 1'b0;
            v_e <= 1'b0;
            v_m <= 1'b1;
            v_w <= v_m;
        end else if (load_use) begin
            v_e <= 1'b0;
            v_m <= v_e;
            v_w <= v_m;
        end else begin
            v_d <= 1'b1;
            v_e <= v_d;
            v_m <= v_e;
            v_w <= v_m;
        end
    end

    // Memory handshake FSM.  MEM_WAIT counts ackless cycles; after
    // MEM_TIMEOUT of them the core halts with a sticky error until reset.
    // If the request vanishes while waiting there is nothing left to wait
    // for, so the FSM returns to RUN just as it does on an acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack || !mem_access) begin
                        state <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (wait_cnt == WAIT_LAST) begin
                            state   <= HALT;
                            mem_err <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

    // Performance counter of cycles in which the PC did not advance, not
    // counting the dead time once the core has halted.  Saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!pc_en && (state != HALT) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage FETCH/DEC/EXE/MEM/WB core.
- Owns per-stage valid bits and produces all stage-register enables.
- Detects load-use hazards (stall plus bubble), squashes wrong-path instructions on taken branches, and selects EXE operand forwarding.
- Runs the data-memory request/acknowledge handshake, with a wait timeout and a stall performance counter.

Parameters:
REG_AW, 4, register-address width (16 architectural registers, none hardwired)
CNT_W, 16, stall-counter width
MEM_TIMEOUT, 15, maximum cycles waiting for dmem_ack before halting

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
dec_rs1  in  REG_AW  rs1 of instruction in DEC
dec_rs2  in  REG_AW  rs2 of instruction in DEC
dec_uses_rs1  in  1  DEC instruction reads rs1
dec_uses_rs2  in  1  DEC instruction reads rs2
exe_rs1  in  REG_AW  rs1 of instruction in EXE
exe_rs2  in  REG_AW  rs2 of instruction in EXE
exe_rd  in  REG_AW  rd of instruction in EXE
exe_is_load  in  1  EXE instruction is a load
exe_needs_wb  in  1  EXE instruction writes the RF
exe_branch_taken  in  1  EXE branch condition true (z_flag on branch)
mem_rd  in  REG_AW  rd in MEM
mem_needs_wb  in  1  MEM instruction writes the RF
mem_is_load  in  1  MEM instruction is a load
mem_is_store  in  1  MEM instruction is a store
wb_rd  in  REG_AW  rd in WB
wb_needs_wb  in  1  WB instruction writes the RF
dmem_ack  in  1  data memory completes the access
pc_en  out  1  PC register load enable
pc_sel  out  1  0 = sequential PC, 1 = branch target (exe_out)
fd_en  out  1  FETCH/DEC register enable
de_en  out  1  DEC/EXE register enable
em_en  out  1  EXE/MEM register enable
mw_en  out  1  MEM/WB register enable
v_d, v_e, v_m, v_w  out  1 each  stage valid bits
wb_valid  out  1  RF write qualifier (v_w & wb_needs_wb)
dmem_req  out  1  data memory request
fwd_a  out  2  EXE operand-1 source: 00 RF, 01 MEM pdata, 10 WB dataout
fwd_b  out  2  EXE operand-2 source, same encoding as fwd_a
stall_cnt  out  CNT_W  saturating stall-cycle count
mem_err  out  1  sticky memory-timeout error

Behaviour:
Reset (async, rst=1):
- All valid bits 0, FSM=RUN, wait counter 0, stall_cnt 0, mem_err 0.
- All enables 0; pc_sel 0; fwd_a/fwd_b 00; dmem_req 0.
- Release takes effect on the next clk edge; the first fetch occurs in that cycle.

FSM states: RUN, MEM_WAIT, HALT.
- mem_access = v_m & (mem_is_load | mem_is_store).
- dmem_req = mem_access & state != HALT (combinational).
- RUN: if dmem_req & ~dmem_ack, go to MEM_WAIT and clear the wait counter. A zero-wait ack in the same cycle stays in RUN.
- MEM_WAIT: counter increments each cycle. On dmem_ack, go to RUN. If the counter reaches MEM_TIMEOUT without ack, go to HALT and set mem_err.
- HALT: dmem_req 0, all enables 0, valid bits frozen. Exits only on rst.

Control, in priority order each cycle:
1. Freeze (dmem_req & ~dmem_ack, or HALT):
   - pc_en, fd_en, de_en, em_en, mw_en all 0.
   - v_w <= 0, so WB is not repeated.
   - v_d, v_e, v_m hold.
2. Branch (v_e & exe_branch_taken):
   - pc_sel=1; all enables 1.
   - v_d <= 0 and v_e <= 0 (squash the two younger instructions).
   - v_m <= 1; v_w <= v_m.
3. Load-use stall (v_d & v_e & exe_is_load & exe_needs_wb & ((dec_uses_rs1 & dec_rs1==exe_rd) | (dec_uses_rs2 & dec_rs2==exe_rd))):
   - pc_en=0, fd_en=0; de_en=1 inserts a bubble, so v_e <= 0.
   - em_en=1, mw_en=1; v_m <= v_e; v_w <= v_m; v_d holds.
4. Normal:
   - All enables 1, pc_sel 0.
   - v_d <= 1, v_e <= v_d, v_m <= v_e, v_w <= v_m.

Forwarding (combinational, evaluated only when v_e):
- fwd_a = 01 if v_m & mem_needs_wb & ~mem_is_load & mem_rd==exe_rs1.
- Otherwise 10 if v_w & wb_needs_wb & wb_rd==exe_rs1.
- Otherwise 00.
- fwd_b uses the same rule on exe_rs2. MEM has priority over WB.

stall_cnt:
- +1 on every cycle with pc_en==0 while state != HALT and not in reset.
- Saturates at all-ones (no wrap).
- Counts the first post-reset cycle only if it stalls.

Test Plan:
- Reset then 4 independent ALU instructions: v_d..v_w become 1 on cycles 1..4; all enables 1; stall_cnt=0.
- Load r3 in EXE, DEC reads r3 as rs2: one cycle with pc_en=0, v_e=0 next; stall_cnt=1; following cycle fwd_b=10.
- ADD r5 in MEM, SUB in EXE reads r5 on rs1, WB also writes r5: fwd_a=01, since MEM wins.
- Taken branch in EXE: pc_sel=1 for 1 cycle; next cycle v_d=0, v_e=0, v_m=1.
- Store in MEM, dmem_ack after 3 cycles: 3 freeze cycles, v_w=0 during freeze, FSM MEM_WAIT→RUN, stall_cnt=3.
- Load in MEM, dmem_ack never arrives: after 15 wait cycles mem_err=1, FSM=HALT, dmem_req=0. Asserting rst mid-HALT clears everything asynchronously.
